// File: rtl/shifter_pkg.sv
// ----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined shifter:
//   - ALU control opcodes understood by the shifter (funct-style codes)
//   - is_legal_op : true for the four supported shift operations
//   - calc_depth  : number of pipeline register slices for a given data
//                   width and number of mux levels per slice
// ----------------------------------------------------------------------------
package shifter_pkg;

    localparam logic [5:0] OP_SLL = 6'b000000;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_ROR = 6'b000110;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

    // ceil(log2(width) / reg_every)
    function automatic int calc_depth(input int width, input int reg_every);
        return ($clog2(width) + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/shift_level.sv
// ----------------------------------------------------------------------------
// shift_level
// One combinational mux level of the shifter: shifts or rotates by the fixed
// distance AMOUNT when enable is set, otherwise passes data through.
//   data    : operand entering this level
//   enable  : the shift-amount bit that selects this level
//   op      : operation code (illegal codes pass data through)
//   sign    : fill bit for arithmetic right shifts
//   shifted : result leaving this level
// ----------------------------------------------------------------------------
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int AMOUNT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic [5:0]       op,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        // NOTE: the default assignment up front covers every path through the
        // case below, so no latch is inferred.
        shifted = data;
        if (enable) begin
            case (op)
                OP_SLL:  shifted = data << AMOUNT;
                OP_SRL:  shifted = data >> AMOUNT;
                OP_SRA:  shifted = {{AMOUNT{sign}}, data[WIDTH-1:AMOUNT]};
                OP_ROR:  shifted = {data[AMOUNT-1:0], data[WIDTH-1:AMOUNT]};
                default: shifted = data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// ----------------------------------------------------------------------------
// pipelined_shifter
// Parametrised SLL/SRL/SRA/ROR shifter. The log2(WIDTH) mux levels are applied
// LSB-first (level k moves data by 2^k) and split into DEPTH register slices
// of REG_EVERY levels each, with a valid/ready handshake on both sides.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset; flushes every slice
//   in_valid  / in_ready  : input handshake (in_ready = slice-0 load enable)
//   dataA     : operand; dataB[SHAMT_W-1:0] : shift amount; Signal : opcode
//   out_valid / out_ready : output handshake
//   dataOut   : shifted result (0 for an illegal opcode)
//   out_err   : result came from an illegal opcode
// All outputs except in_ready come straight from the last slice registers.
// ----------------------------------------------------------------------------
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             out_err
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int DEPTH   = calc_depth(WIDTH, REG_EVERY);

    // Slice registers
    logic [DEPTH-1:0]   slice_valid;
    logic [WIDTH-1:0]   slice_data  [DEPTH];
    logic [SHAMT_W-1:0] slice_shamt [DEPTH];
    logic [5:0]         slice_op    [DEPTH];
    logic [DEPTH-1:0]   slice_sign;
    logic [DEPTH-1:0]   slice_err;

    // What each slice would capture: control from the slice behind it (or the
    // input port) and data after that slice's group of mux levels.
    logic [DEPTH-1:0]   src_valid;
    logic [SHAMT_W-1:0] src_shamt [DEPTH];
    logic [5:0]         src_op    [DEPTH];
    logic [DEPTH-1:0]   src_sign;
    logic [DEPTH-1:0]   src_err;
    logic [WIDTH-1:0]   stage_data [DEPTH];

    logic [DEPTH:0]     load;
    logic               in_legal;
    logic               unused_fold;

    assign in_legal = is_legal_op(Signal);

    // Illegal ops enter as zero data with a zero sign, so the levels (which
    // pass illegal codes through) carry a zero result to the output.
    generate
        for (genvar k = 0; k < SHAMT_W; k++) begin : gen_lvl
            localparam int S = k / REG_EVERY;
            logic [WIDTH-1:0] lvl_in;
            logic [WIDTH-1:0] lvl_out;
            logic             lvl_en;
            logic [5:0]       lvl_op;
            logic             lvl_sign;

            if (S == 0) begin : g_from_port
                assign lvl_en   = dataB[k];
                assign lvl_op   = Signal;
                assign lvl_sign = in_legal & dataA[WIDTH-1];
            end else begin : g_from_slice
                assign lvl_en   = slice_shamt[S-1][k];
                assign lvl_op   = slice_op[S-1];
                assign lvl_sign = slice_sign[S-1];
            end

            if (k % REG_EVERY == 0) begin : g_group_head
                if (S == 0) begin : g_head_port
                    assign lvl_in = in_legal ? dataA : '0;
                end else begin : g_head_slice
                    assign lvl_in = slice_data[S-1];
                end
            end else begin : g_chain
                assign lvl_in = gen_lvl[k-1].lvl_out;
            end

            shift_level #(
                .WIDTH  (WIDTH),
                .AMOUNT (1 << k)
            ) u_level (
                .data    (lvl_in),
                .enable  (lvl_en),
                .op      (lvl_op),
                .sign    (lvl_sign),
                .shifted (lvl_out)
            );

            if ((k % REG_EVERY == REG_EVERY - 1) || (k == SHAMT_W - 1)) begin : g_group_tail
                assign stage_data[S] = lvl_out;
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                src_valid[i] = in_valid;
                src_shamt[i] = dataB[SHAMT_W-1:0];
                src_op[i]    = Signal;
                src_sign[i]  = in_legal & dataA[WIDTH-1];
                src_err[i]   = ~in_legal;
            end else begin
                src_valid[i] = slice_valid[i-1];
                src_shamt[i] = slice_shamt[i-1];
                src_op[i]    = slice_op[i-1];
                src_sign[i]  = slice_sign[i-1];
                src_err[i]   = slice_err[i-1];
            end
        end
    end

    // A slice loads when it is empty or its contents move on this cycle; the
    // chain runs from the output handshake back to in_ready, so bubbles fill.
    always_comb begin
        load[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            load[i] = ~slice_valid[i] | load[i+1];
        end
    end

    assign in_ready = load[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: data registers are reset too (not just valid bits) so the
            // outputs never show X, even before the first result arrives.
            slice_valid <= '0;
            slice_sign  <= '0;
            slice_err   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slice_data[i]  <= '0;
                slice_shamt[i] <= '0;
                slice_op[i]    <= OP_SLL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load[i]) begin
                    // NOTE: non-blocking assignments so every slice samples its
                    // neighbour's value from before this edge.
                    slice_valid[i] <= src_valid[i];
                    // Bubbles leave the payload untouched.
                    if (src_valid[i]) begin
                        slice_data[i]  <= stage_data[i];
                        slice_shamt[i] <= src_shamt[i];
                        slice_op[i]    <= src_op[i];
                        slice_sign[i]  <= src_sign[i];
                        slice_err[i]   <= src_err[i];
                    end
                end
            end
        end
    end

    assign out_valid = slice_valid[DEPTH-1];
    assign dataOut   = slice_data[DEPTH-1];
    assign out_err   = slice_err[DEPTH-1];

    // Upper dataB bits and the last slice's control fields have no consumer.
    always_comb begin
        unused_fold = ^dataB ^ (^slice_sign);
        for (int i = 0; i < DEPTH; i++) begin
            unused_fold = unused_fold ^ (^slice_shamt[i]) ^ (^slice_op[i]);
        end
    end

endmodule
